// File: rtl/count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// count_ctrl_pkg
// Shared definitions for the up/down count controller: mode encodings, the
// mode-field width and the default counter geometry.
// -----------------------------------------------------------------------------
package count_ctrl_pkg;

   localparam int MODE_W      = 2;
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MAX_VAL = 9;

   // Encoding 3 is never produced; it falls back to WRAP if ever seen.
   typedef enum logic [MODE_W-1:0] {
      MODE_WRAP = 2'd0,
      MODE_SAT  = 2'd1,
      MODE_LOCK = 2'd2
   } mode_t;

   // WRAP -> SAT -> LOCK -> WRAP
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_WRAP: next_mode = MODE_SAT;
         MODE_SAT:  next_mode = MODE_LOCK;
         default:   next_mode = MODE_WRAP;
      endcase
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// Turns a debounced, clk-synchronous button level into a single-cycle event.
// The event is asserted in the cycle the level is first sampled high after
// having been low, so a held button yields exactly one event.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; history is forced to 1 so a button
//           held across reset release must be seen low before it can fire
//   level : button level
//   pulse : rising-edge event (combinational from level and history)
// -----------------------------------------------------------------------------
module btn_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev;

   // NOTE: registers are written with non-blocking assignments so every flop
   // samples the pre-edge value of its inputs, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b1;
      else     prev <= level;
   end

   assign pulse = level & ~prev;

endmodule

// File: rtl/updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl
// Button-driven up/down counter with three operating modes:
//   WRAP : count wraps 0 <-> MAX_VAL and sets the sticky 'wrapped' flag
//   SAT  : count saturates at 0 and MAX_VAL
//   LOCK : inc/dec ignored; clr still works
// Event priority is clr > mode > inc/dec. All state updates one cycle after
// the button edge is sampled.
//
// Ports
//   clk, rst                 : clock and synchronous active-high reset
//   inc_btn, dec_btn,
//   clr_btn, mode_btn        : debounced button levels
//   count  [WIDTH-1:0]       : current count
//   mode   [MODE_W-1:0]      : current mode (WRAP=0, SAT=1, LOCK=2)
//   at_max, at_min           : count == MAX_VAL / count == 0
//   wrapped                  : sticky, set on any wrap, cleared by clr/reset
//   conflict                 : one-cycle pulse when inc and dec coincide
// -----------------------------------------------------------------------------
module updown_count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MAX_VAL = DEF_MAX_VAL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_btn,
   input  logic              dec_btn,
   input  logic              clr_btn,
   input  logic              mode_btn,
   output logic [WIDTH-1:0]  count,
   output logic [MODE_W-1:0] mode,
   output logic              at_max,
   output logic              at_min,
   output logic              wrapped,
   output logic              conflict
);

   // One extra bit so that +1 at MAX_VAL = 2**WIDTH-1 and -1 at 0 are visible.
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

   logic inc_ev, dec_ev, clr_ev, mode_ev;

   btn_edge_sync u_inc  (.clk(clk), .rst(rst), .level(inc_btn),  .pulse(inc_ev));
   btn_edge_sync u_dec  (.clk(clk), .rst(rst), .level(dec_btn),  .pulse(dec_ev));
   btn_edge_sync u_clr  (.clk(clk), .rst(rst), .level(clr_btn),  .pulse(clr_ev));
   btn_edge_sync u_mode (.clk(clk), .rst(rst), .level(mode_btn), .pulse(mode_ev));

   logic [WIDTH-1:0] count_q,    count_d;
   mode_t            mode_q,     mode_d;
   logic             wrapped_q,  wrapped_d;
   logic             conflict_q, conflict_d;

   logic [WIDTH:0]   cnt_inc, cnt_dec;

   assign cnt_inc = {1'b0, count_q} + (WIDTH+1)'(1);
   assign cnt_dec = {1'b0, count_q} - (WIDTH+1)'(1);

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      count_d    = count_q;
      mode_d     = mode_q;
      wrapped_d  = wrapped_q;
      conflict_d = 1'b0;

      if (clr_ev) begin
         count_d   = '0;
         wrapped_d = 1'b0;
      end else if (mode_ev) begin
         mode_d = next_mode(mode_q);
      end else if (mode_q != MODE_LOCK) begin
         if (inc_ev && dec_ev) begin
            conflict_d = 1'b1;
         end else if (inc_ev) begin
            if (cnt_inc > MAX_EXT) begin
               // At the top: WRAP rolls over, SAT holds.
               if (mode_q == MODE_WRAP) begin
                  count_d   = '0;
                  wrapped_d = 1'b1;
               end
            end else begin
               count_d = cnt_inc[WIDTH-1:0];
            end
         end else if (dec_ev) begin
            // Borrow out of the extended subtraction means count was 0.
            if (cnt_dec[WIDTH]) begin
               if (mode_q == MODE_WRAP) begin
                  count_d   = MAX_EXT[WIDTH-1:0];
                  wrapped_d = 1'b1;
               end
            end else begin
               count_d = cnt_dec[WIDTH-1:0];
            end
         end
      end
   end

   // Reset is synchronous and overrides any event sampled in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         mode_q     <= MODE_WRAP;
         wrapped_q  <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         mode_q     <= mode_d;
         wrapped_q  <= wrapped_d;
         conflict_q <= conflict_d;
      end
   end

   assign count    = count_q;
   assign mode     = mode_q;
   assign wrapped  = wrapped_q;
   assign conflict = conflict_q;
   assign at_max   = (count_q == MAX_EXT[WIDTH-1:0]);
   assign at_min   = (count_q == '0);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_count_ctrl
// Directed stimulus with hand-computed expectations. Each stimulus step drives
// one cycle of button levels and pushes the state expected after that edge
// into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_updown_count_ctrl;

   localparam int WIDTH   = 4;
   localparam int MAX_VAL = 9;

   logic             clk;
   logic             rst;
   logic             inc_btn, dec_btn, clr_btn, mode_btn;
   logic [WIDTH-1:0] count;
   logic [1:0]       mode;
   logic             at_max, at_min, wrapped, conflict;

   updown_count_ctrl #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
      .clk      (clk),
      .rst      (rst),
      .inc_btn  (inc_btn),
      .dec_btn  (dec_btn),
      .clr_btn  (clr_btn),
      .mode_btn (mode_btn),
      .count    (count),
      .mode     (mode),
      .at_max   (at_max),
      .at_min   (at_min),
      .wrapped  (wrapped),
      .conflict (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    cnt;
      int    md;
      int    wr;
      int    cf;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: compares DUT state against the oldest pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check({mon_e.name, ".count"},    int'(count),    mon_e.cnt);
         check({mon_e.name, ".mode"},     int'(mode),     mon_e.md);
         check({mon_e.name, ".wrapped"},  int'(wrapped),  mon_e.wr);
         check({mon_e.name, ".conflict"}, int'(conflict), mon_e.cf);
         check({mon_e.name, ".at_max"},   int'(at_max),   (mon_e.cnt == MAX_VAL) ? 1 : 0);
         check({mon_e.name, ".at_min"},   int'(at_min),   (mon_e.cnt == 0) ? 1 : 0);
      end
   end

   // One clock of stimulus plus the state expected right after that edge.
   task automatic step(input string name,
                       input bit i, input bit d, input bit c, input bit m, input bit r,
                       input int e_cnt, input int e_md, input int e_wr, input int e_cf);
      exp_t e;
      @(negedge clk);
      #1;
      inc_btn  = i;
      dec_btn  = d;
      clr_btn  = c;
      mode_btn = m;
      rst      = r;
      @(posedge clk);
      e.name = name;
      e.cnt  = e_cnt;
      e.md   = e_md;
      e.wr   = e_wr;
      e.cf   = e_cf;
      exp_q.push_back(e);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; inc_btn = 1'b0; dec_btn = 1'b0; clr_btn = 1'b0; mode_btn = 1'b0;

      // Reset state
      step("rst0", 0,0,0,0,1, 0,0,0,0);
      step("rst1", 0,0,0,0,1, 0,0,0,0);
      step("idle", 0,0,0,0,0, 0,0,0,0);

      // WRAP: ten isolated inc presses, 1..9 then 0 with wrapped set
      for (int k = 1; k <= 10; k++) begin
         cnt = k % 10;
         step("wrap_inc",     1,0,0,0,0, cnt,0,(k == 10) ? 1 : 0,0);
         step("wrap_inc_rel", 0,0,0,0,0, cnt,0,(k == 10) ? 1 : 0,0);
      end

      // SAT: climb to 9, inc holds; descend to 0, dec holds
      step("to_sat",     0,0,0,1,0, 0,1,1,0);
      step("to_sat_rel", 0,0,0,0,0, 0,1,1,0);
      for (int k = 1; k <= 9; k++) begin
         step("sat_up",     1,0,0,0,0, k,1,1,0);
         step("sat_up_rel", 0,0,0,0,0, k,1,1,0);
      end
      step("sat_max",     1,0,0,0,0, 9,1,1,0);
      step("sat_max_rel", 0,0,0,0,0, 9,1,1,0);
      for (int k = 8; k >= 0; k--) begin
         step("sat_dn",     0,1,0,0,0, k,1,1,0);
         step("sat_dn_rel", 0,0,0,0,0, k,1,1,0);
      end
      step("sat_min",     0,1,0,0,0, 0,1,1,0);
      step("sat_min_rel", 0,0,0,0,0, 0,1,1,0);
      for (int k = 1; k <= 3; k++) begin
         step("sat_up3",     1,0,0,0,0, k,1,1,0);
         step("sat_up3_rel", 0,0,0,0,0, k,1,1,0);
      end

      // LOCK: inc/dec ignored, no conflict; clr works; next mode is WRAP
      step("to_lock",      0,0,0,1,0, 3,2,1,0);
      step("to_lock_rel",  0,0,0,0,0, 3,2,1,0);
      step("lock_inc",     1,0,0,0,0, 3,2,1,0);
      step("lock_inc_rel", 0,0,0,0,0, 3,2,1,0);
      step("lock_dec",     0,1,0,0,0, 3,2,1,0);
      step("lock_dec_rel", 0,0,0,0,0, 3,2,1,0);
      step("lock_both",    1,1,0,0,0, 3,2,1,0);
      step("lock_both_rel",0,0,0,0,0, 3,2,1,0);
      step("lock_clr",     0,0,1,0,0, 0,2,0,0);
      step("lock_clr_rel", 0,0,0,0,0, 0,2,0,0);
      step("lock_to_wrap", 0,0,0,1,0, 0,0,0,0);
      step("wrap_rel",     0,0,0,0,0, 0,0,0,0);

      // Conflict at 5 in WRAP: one-cycle pulse, count holds
      for (int k = 1; k <= 5; k++) begin
         step("up5",     1,0,0,0,0, k,0,0,0);
         step("up5_rel", 0,0,0,0,0, k,0,0,0);
      end
      step("conflict",     1,1,0,0,0, 5,0,0,1);
      step("conflict_end", 0,0,0,0,0, 5,0,0,0);

      // Down through 0 (wrap to 9) and on to 3
      for (int k = 4; k >= 0; k--) begin
         step("dn",     0,1,0,0,0, k,0,0,0);
         step("dn_rel", 0,0,0,0,0, k,0,0,0);
      end
      step("dn_wrap",     0,1,0,0,0, 9,0,1,0);
      step("dn_wrap_rel", 0,0,0,0,0, 9,0,1,0);
      for (int k = 8; k >= 3; k--) begin
         step("dn3",     0,1,0,0,0, k,0,1,0);
         step("dn3_rel", 0,0,0,0,0, k,0,1,0);
      end

      // clr beats inc; mode beats inc
      step("clr_inc",     1,0,1,0,0, 0,0,0,0);
      step("clr_inc_rel", 0,0,0,0,0, 0,0,0,0);
      step("mode_inc",    1,0,0,1,0, 0,1,0,0);
      step("mode_inc_rel",0,0,0,0,0, 0,1,0,0);
      step("m_lock",      0,0,0,1,0, 0,2,0,0);
      step("m_lock_rel",  0,0,0,0,0, 0,2,0,0);
      step("m_wrap",      0,0,0,1,0, 0,0,0,0);
      step("m_wrap_rel",  0,0,0,0,0, 0,0,0,0);

      // Held inc: exactly one increment
      for (int k = 0; k < 20; k++)
         step("hold_inc", 1,0,0,0,0, 1,0,0,0);
      step("hold_rel", 0,0,0,0,0, 1,0,0,0);

      // Inc held across reset: no event until low then high again
      step("pre_sat",     0,0,0,1,0, 1,1,0,0);
      step("pre_sat_rel", 0,0,0,0,0, 1,1,0,0);
      step("inc_up",      1,0,0,0,0, 2,1,0,0);
      step("inc_rst",     1,0,0,0,1, 0,0,0,0);
      for (int k = 0; k < 4; k++)
         step("inc_after_rst", 1,0,0,0,0, 0,0,0,0);
      step("inc_low",   0,0,0,0,0, 0,0,0,0);
      step("inc_again", 1,0,0,0,0, 1,0,0,0);
      step("inc_again_rel", 0,0,0,0,0, 1,0,0,0);

      // Reset in the same cycle as an inc edge wins
      step("rst_edge",     1,0,0,0,1, 0,0,0,0);
      step("rst_edge_rel", 0,0,0,0,0, 0,0,0,0);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && exp_q.size() > 0; k++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: pending %0d expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
